// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes, condition encodings
// and the flag-based condition evaluator used by writeback.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_AW = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_N      = 3'd3,
    COND_P      = 3'd4,
    COND_NZE    = 3'd5,
    COND_PZE    = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  typedef struct packed {
    logic neg;
    logic pos;
    logic zero;
  } flags_t;

  function automatic logic cond_eval(input cond_e sel, input flags_t f);
    logic r;
    r = 1'b0;
    unique case (sel)
      COND_ALWAYS: r = 1'b1;
      COND_Z:      r = f.zero;
      COND_NZ:     r = !f.zero;
      COND_N:      r = f.neg;
      COND_P:      r = f.pos;
      COND_NZE:    r = f.neg | f.zero;
      COND_PZE:    r = f.pos | f.zero;
      COND_NEVER:  r = 1'b0;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular write queue with synchronous flush; exposes per-entry valid bits and
// tag fields so the parent can build a register-pending mask.
module wb_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [W-1:0]                data_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [W-1:0]                head_o,
  output logic [DEPTH-1:0]            vld_o,
  output logic [DEPTH-1:0][TAG_W-1:0] tag_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign head_o  = mem_q[head_q];
  assign vld_o   = vld_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) tag_o[i] = mem_q[i][W-1 -: TAG_W];
  end

  // Flush wins over any concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= data_i;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= ptr_inc(tail_q);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= ptr_inc(head_q);
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: architectural flags, branch condition, and a stallable
// write queue toward the register file with a per-register pending mask.
module alu_writeback #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_AW-1:0]      in_rd,
  input  logic                   in_wr,
  input  logic                   in_set_flags,
  input  logic [DATA_W-1:0]      in_c,
  input  logic                   in_neg,
  input  logic                   in_pos,
  input  logic                   in_zero,
  input  logic                   flush,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [REG_AW-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   flag_neg,
  output logic                   flag_pos,
  output logic                   flag_zero,
  input  logic [2:0]             cond_sel,
  output logic                   cond_true,
  output logic [2**REG_AW-1:0]   pending
);

  import cpu_pkg::*;

  localparam int EW = REG_AW + DATA_W;

  logic                            full, empty, xfer;
  logic [EW-1:0]                   head;
  logic [DEPTH-1:0]                ent_vld;
  logic [DEPTH-1:0][REG_AW-1:0]    ent_rd;
  flags_t                          flags_q;

  assign in_ready = !full && !flush;
  assign xfer     = in_valid && in_ready;

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .TAG_W (REG_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (xfer && in_wr),
    .data_i  ({in_rd, in_c}),
    .pop_i   (wb_ready),
    .flush_i (flush),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .vld_o   (ent_vld),
    .tag_o   (ent_rd)
  );

  assign wb_valid = !empty;
  assign wb_addr  = head[EW-1 -: REG_AW];
  assign wb_data  = head[DATA_W-1:0];

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending[ent_rd[i]] = 1'b1;
    end
  end

  // Reset value matches the flags of a zero result; flush never touches flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '{neg: 1'b0, pos: 1'b0, zero: 1'b1};
    end else if (xfer && in_set_flags) begin
      flags_q <= '{neg: in_neg, pos: in_pos, zero: in_zero};
    end
  end

  assign flag_neg  = flags_q.neg;
  assign flag_pos  = flags_q.pos;
  assign flag_zero = flags_q.zero;
  assign cond_true = cond_eval(cond_e'(cond_sel), flags_q);

endmodule
